// File: rtl/uart_load_controller.sv
// uart_load_controller: sequences a UART program download into the
// instruction and data memories on behalf of the hazard unit.
//
// Optional feature: define UART_LOAD_TIMEOUT_EN to enable the idle-word
// timeout counter. Without it, RECEIVE waits indefinitely for upg_done
// and load_timeout is held at 0.
//
// Handshake: upg_wen is a single-cycle valid strobe with no ready/back-pressure.
// A word presented while the FSM is in RECEIVE is accepted on that rising edge,
// and its memory write (*_we with registered addr/wdata) is visible for exactly
// the following cycle. Strobes seen in any other state are discarded.
//
// dbg_state exposes the FSM encoding (IDLE=0, ARM=1, RECEIVE=2, DONE=3, ABORT=4).

module uart_load_controller #(
  parameter int IMEM_DEPTH_WORDS = 16384,
  parameter int DMEM_DEPTH_WORDS = 16384,
  parameter int TIMEOUT_CYCLES   = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic        upg_wen,
  input  logic [14:0] upg_adr,
  input  logic [31:0] upg_dat,
  input  logic        upg_done,
  output logic        uart_rst,
  output logic        imem_we,
  output logic [13:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        dmem_we,
  output logic [13:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        load_busy,
  output logic        load_complete,
  output logic [15:0] word_count,
  output logic        addr_error,
  output logic        load_timeout,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_RECEIVE = 3'd2,
    S_DONE    = 3'd3,
    S_ABORT   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        sel_dmem;
  logic        in_range;
  logic        timeout_hit;
  logic        start_load;
  logic [13:0] word_adr;

  assign word_adr   = upg_adr[13:0];
  assign sel_dmem   = upg_adr[14];
  assign accept     = (state == S_RECEIVE) && upg_wen;
  assign start_load = (state == S_IDLE) && load_req;
  assign dbg_state  = state;

  // Bounds check of the word address against the selected memory's depth
  always_comb begin
    in_range = 1'b0;
    if (sel_dmem) begin
      in_range = (32'(word_adr) < DMEM_DEPTH_WORDS);
    end else begin
      in_range = (32'(word_adr) < IMEM_DEPTH_WORDS);
    end
  end

`ifdef UART_LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_count;
  logic          tmo_phase;

  // Idle counter: restarts outside RECEIVE and on every accepted word,
  // advancing once per two RECEIVE cycles
  always_ff @(posedge clk) begin
    if (rst || (state != S_RECEIVE) || accept) begin
      tmo_count <= '0;
      tmo_phase <= 1'b0;
    end else begin
      tmo_phase <= ~tmo_phase;
      if (tmo_phase) begin
        tmo_count <= tmo_count + 1'b1;
      end
    end
  end

  assign timeout_hit = (state == S_RECEIVE) && (tmo_count >= TW'(TIMEOUT_CYCLES));
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_hit        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs; upg_done wins over timeout
  always_comb begin
    state_nxt     = state;
    uart_rst      = 1'b1;
    load_busy     = 1'b0;
    load_complete = 1'b0;
    load_timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_req) begin
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        uart_rst  = 1'b0;
        load_busy = 1'b1;
        state_nxt = S_RECEIVE;
      end
      S_RECEIVE: begin
        uart_rst  = 1'b0;
        load_busy = 1'b1;
        if (upg_done) begin
          state_nxt = S_DONE;
        end else if (timeout_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_DONE: begin
        load_complete = 1'b1;
        state_nxt     = S_IDLE;
      end
      S_ABORT: begin
`ifdef UART_LOAD_TIMEOUT_EN
        load_timeout = 1'b1;
`endif
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered write port: one cycle after acceptance, only for in-range words
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_we <= accept && !sel_dmem && in_range;
      dmem_we <= accept && sel_dmem && in_range;
      if (accept && in_range && !sel_dmem) begin
        imem_addr  <= word_adr;
        imem_wdata <= upg_dat;
      end
      if (accept && in_range && sel_dmem) begin
        dmem_addr  <= word_adr;
        dmem_wdata <= upg_dat;
      end
    end
  end

  // Per-load statistics: cleared as ARM is entered, updated on each accepted word
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
      addr_error <= 1'b0;
    end else if (start_load) begin
      word_count <= '0;
      addr_error <= 1'b0;
    end else if (accept) begin
      if (word_count != 16'hFFFF) begin
        word_count <= word_count + 16'd1;
      end
      if (!in_range) begin
        addr_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_load_controller.sv
// Testbench for uart_load_controller with a small instruction memory (1024
// words), a 2048-word data memory and an 8-count timeout. Compile with
// +define+UART_LOAD_TIMEOUT_EN to exercise the timeout abort path.

module tb_uart_load_controller;

  localparam int IMEM_D = 1024;
  localparam int DMEM_D = 2048;
  localparam int TMO    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_RECEIVE = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ABORT   = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        upg_wen;
  logic [14:0] upg_adr;
  logic [31:0] upg_dat;
  logic        upg_done;
  logic        uart_rst;
  logic        imem_we;
  logic [13:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        dmem_we;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        load_busy;
  logic        load_complete;
  logic [15:0] word_count;
  logic        addr_error;
  logic        load_timeout;
  logic [2:0]  dbg_state;

  // Clock
  always #5 clk = ~clk;

  uart_load_controller #(
    .IMEM_DEPTH_WORDS(IMEM_D),
    .DMEM_DEPTH_WORDS(DMEM_D),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .upg_wen      (upg_wen),
    .upg_adr      (upg_adr),
    .upg_dat      (upg_dat),
    .upg_done     (upg_done),
    .uart_rst     (uart_rst),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .load_busy    (load_busy),
    .load_complete(load_complete),
    .word_count   (word_count),
    .addr_error   (addr_error),
    .load_timeout (load_timeout),
    .dbg_state    (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_timeout = 0;

  // Expected writes: {is_dmem, word address, data}
  logic [46:0] exp_q[$];

  typedef struct {
    logic [14:0] adr;
    logic [31:0] dat;
    logic        exp_wr;
    logic [15:0] exp_cnt;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    logic [46:0] got;
    logic [46:0] want;
    if (load_timeout) cnt_timeout++;
    if (imem_we || dmem_we) begin
      chk("we_exclusive", 32'(imem_we & dmem_we), 32'd0);
      got = dmem_we ? {1'b1, dmem_addr, dmem_wdata} : {1'b0, imem_addr, imem_wdata};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got dmem=%0d addr=0x%0h data=0x%0h expected no write",
                 got[46], got[45:32], got[31:0]);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL write: got dmem=%0d addr=0x%0h data=0x%0h expected dmem=%0d addr=0x%0h data=0x%0h",
                   got[46], got[45:32], got[31:0], want[46], want[45:32], want[31:0]);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    load_req = 1'b0;
    upg_wen  = 1'b0;
    upg_done = 1'b0;
    upg_adr  = '0;
    upg_dat  = '0;

    vecs[0] = '{15'h0003, 32'hDEADBEEF, 1'b1, 16'd1, 1'b0};
    vecs[1] = '{15'h4010, $urandom,     1'b1, 16'd2, 1'b0};
    vecs[2] = '{15'h03FF, $urandom,     1'b1, 16'd3, 1'b0};
    vecs[3] = '{15'h0400, $urandom,     1'b0, 16'd4, 1'b1};
    vecs[4] = '{15'h47FF, $urandom,     1'b1, 16'd5, 1'b1};
    vecs[5] = '{15'h4800, $urandom,     1'b0, 16'd6, 1'b1};
    vecs[6] = '{15'h3FFF, $urandom,     1'b0, 16'd7, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_uart_rst", 32'(uart_rst), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_addr_error", 32'(addr_error), 32'd0);
    chk("rst_complete", 32'(load_complete), 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    rst = 1'b0;

    // First load: ARM then RECEIVE, load_req dropped during ARM
    load_req = 1'b1;
    @(negedge clk);
    chk("arm_state", 32'(dbg_state), 32'(ST_ARM));
    chk("arm_uart_rst", 32'(uart_rst), 32'd0);
    chk("arm_busy", 32'(load_busy), 32'd1);
    load_req = 1'b0;
    @(negedge clk);
    chk("recv_state", 32'(dbg_state), 32'(ST_RECEIVE));
    chk("recv_uart_rst", 32'(uart_rst), 32'd0);

    // Table of words in RECEIVE
    for (int i = 0; i < 7; i++) begin
      upg_wen = 1'b1;
      upg_adr = vecs[i].adr;
      upg_dat = vecs[i].dat;
      if (vecs[i].exp_wr) exp_q.push_back({vecs[i].adr[14], vecs[i].adr[13:0], vecs[i].dat});
      @(negedge clk);
      upg_wen = 1'b0;
      chk($sformatf("vec%0d_word_count", i), 32'(word_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_addr_error", i), 32'(addr_error), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(ST_RECEIVE));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Word coinciding with upg_done still writes, then DONE pulse
    upg_wen  = 1'b1;
    upg_done = 1'b1;
    upg_adr  = 15'h4010;
    upg_dat  = 32'hCAFEF00D;
    exp_q.push_back({1'b1, 14'h0010, 32'hCAFEF00D});
    @(negedge clk);
    upg_wen  = 1'b0;
    upg_done = 1'b0;
    chk("done_state", 32'(dbg_state), 32'(ST_DONE));
    chk("done_complete", 32'(load_complete), 32'd1);
    chk("done_uart_rst", 32'(uart_rst), 32'd1);
    chk("done_busy", 32'(load_busy), 32'd0);
    chk("done_word_count", 32'(word_count), 32'd8);
    @(negedge clk);
    chk("post_done_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("post_done_complete", 32'(load_complete), 32'd0);

    // Strobes outside RECEIVE are ignored
    upg_wen  = 1'b1;
    upg_done = 1'b1;
    upg_adr  = 15'h0005;
    upg_dat  = $urandom;
    @(negedge clk);
    upg_wen  = 1'b0;
    upg_done = 1'b0;
    chk("idle_ignore_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("idle_ignore_count", 32'(word_count), 32'd8);

    // Second load: ARM clears statistics; a strobe during ARM is ignored
    load_req = 1'b1;
    @(negedge clk);
    chk("arm2_state", 32'(dbg_state), 32'(ST_ARM));
    chk("arm2_word_count", 32'(word_count), 32'd0);
    chk("arm2_addr_error", 32'(addr_error), 32'd0);
    upg_wen = 1'b1;
    upg_adr = 15'h0009;
    @(negedge clk);
    upg_wen = 1'b0;
    chk("recv2_state", 32'(dbg_state), 32'(ST_RECEIVE));
    chk("arm_ignore_count", 32'(word_count), 32'd0);
    upg_done = 1'b1;
    @(negedge clk);
    upg_done = 1'b0;
    chk("done2_state", 32'(dbg_state), 32'(ST_DONE));
    @(negedge clk);
    chk("idle2_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    chk("rearm_state", 32'(dbg_state), 32'(ST_ARM));
    load_req = 1'b0;
    @(negedge clk);
    chk("recv3_state", 32'(dbg_state), 32'(ST_RECEIVE));

    // Reset arriving with an accepted word drops the write
    upg_wen = 1'b1;
    upg_adr = 15'h0007;
    upg_dat = $urandom;
    rst     = 1'b1;
    @(negedge clk);
    upg_wen = 1'b0;
    chk("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_mid_word_count", 32'(word_count), 32'd0);
    chk("rst_mid_uart_rst", 32'(uart_rst), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Idle RECEIVE with no words
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    chk("recv4_state", 32'(dbg_state), 32'(ST_RECEIVE));
`ifdef UART_LOAD_TIMEOUT_EN
    for (int i = 0; i < 60 && !load_timeout; i++) @(negedge clk);
    chk("timeout_pulse", 32'(load_timeout), 32'd1);
    chk("timeout_state", 32'(dbg_state), 32'(ST_ABORT));
    chk("timeout_no_complete", 32'(load_complete), 32'd0);
    chk("timeout_uart_rst", 32'(uart_rst), 32'd1);
    @(negedge clk);
    chk("post_timeout_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("post_timeout_pulse", 32'(load_timeout), 32'd0);
`else
    repeat (1000) @(negedge clk);
    chk("no_timeout_state", 32'(dbg_state), 32'(ST_RECEIVE));
    chk("no_timeout_pulses", 32'(cnt_timeout), 32'd0);
    upg_done = 1'b1;
    @(negedge clk);
    upg_done = 1'b0;
    chk("done4_state", 32'(dbg_state), 32'(ST_DONE));
    @(negedge clk);
`endif

    chk("writes_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
